// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch with redirect, halt and a
// valid/ready handshake toward decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] next_address,
  input  logic        redirect,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;
  state_t r_state, w_next;
  logic [31:0] r_pc, r_fetch_pc, r_instr, r_instr_pc;
  logic r_drop, r_instr_valid;
  logic w_grant, w_take;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      FETCH:  w_next = redirect ? FETCH : halt ? HALTED : imem_gnt ? WAIT : FETCH;
      WAIT:   w_next = !imem_rvalid ? WAIT : redirect ? FETCH : r_drop ? (halt ? HALTED : FETCH) : HOLD;
      HOLD:   w_next = redirect ? FETCH : instr_ready ? (halt ? HALTED : FETCH) : HOLD;
      HALTED: w_next = (redirect || halt) ? HALTED : FETCH;
    endcase
  end
  // reset is folded in so the request is low for the whole reset window
  always_comb begin
    imem_req    = !rst && r_state == FETCH && !redirect && !halt;
    imem_addr   = r_pc;
    instr_valid = r_instr_valid;
    instr       = r_instr;
    instr_pc    = r_instr_pc;
    w_grant     = imem_req && imem_gnt;
    w_take      = r_state == WAIT && imem_rvalid && !redirect && !r_drop;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pc          <= RESET_PC;
      r_fetch_pc    <= '0;
      r_drop        <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
    end else begin
      if (redirect) r_pc <= next_address;
      else if (w_grant) r_pc <= r_pc + 32'd1;
      if (w_grant) r_fetch_pc <= r_pc;
      // a redirect while waiting poisons the in-flight response
      if (r_state == WAIT) r_drop <= imem_rvalid ? 1'b0 : (r_drop || redirect);
      if (w_take) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_fetch_pc;
      end
      if (w_take) r_instr_valid <= 1'b1;
      else if (r_state == HOLD && (redirect || instr_ready)) r_instr_valid <= 1'b0;
    end
endmodule
